instruction_fetch_unit: RTL and testbench
=========================================

INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL set the PC loaded on reset.
REQ-002 Port clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 Port reset_n  input  1  SHALL be the reset: asynchronous, active-low.
REQ-004 Port imem_req_valid  output  1  SHALL indicate a fetch request to instruction memory.
REQ-005 Port imem_req_addr  output  32  SHALL carry the word-aligned fetch address (current PC).
REQ-006 Port imem_req_ready  input  1  SHALL indicate memory accepts the request this cycle.
REQ-007 Port imem_resp_valid  input  1  SHALL indicate imem_resp_data is valid this cycle.
REQ-008 Port imem_resp_data  input  32  SHALL carry the fetched instruction word.
REQ-009 Port inst_valid  output  1  SHALL indicate inst/inst_pc hold an instruction for the decode stage (opcode, funct and immediate fields).
REQ-010 Port inst  output  32  SHALL be the latched instruction register.
REQ-011 Port inst_pc  output  32  SHALL be the address inst was fetched from.
REQ-012 Port inst_ready  input  1  SHALL indicate downstream consumes inst this cycle.
REQ-013 Port redirect_valid / redirect_pc  input  1 / 32  SHALL request a PC change (branch/JAL/JALR target).
REQ-014 Port halt  input  1  SHALL request a stop after the currently held instruction is consumed.
REQ-015 Port fetch_count  output  32  SHALL count completed inst handshakes.

Function
REQ-016 FSM states SHALL be IDLE, REQ, WAIT, DRAIN, HOLD, HALTED.
REQ-017 IDLE SHALL go to REQ unconditionally on the next edge; no outputs are asserted in IDLE.
REQ-018 In REQ, imem_req_valid=1 and imem_req_addr=PC; on imem_req_ready the FSM SHALL go to WAIT.
REQ-019 In WAIT, on imem_resp_valid: inst<=imem_resp_data, inst_pc<=PC, PC<=PC+4, go to HOLD.
REQ-020 In HOLD, inst_valid=1; inst and inst_pc SHALL stay stable until handshake (inst_valid & inst_ready).
REQ-021 On a HOLD handshake: fetch_count+=1, then go to HALTED if halt=1, else REQ.
REQ-022 PC arithmetic SHALL be 32-bit modulo: 32'hFFFF_FFFC+4 = 32'h0000_0000; fetch_count wraps likewise.
REQ-023 redirect_pc[1:0] SHALL be forced to 2'b00 when loaded into PC.
REQ-024 Redirect in IDLE/REQ: PC<=redirect_pc; the state is REQ next cycle (request re-issued at new address, even if imem_req_ready was 1 that cycle, in which case the FSM goes to DRAIN instead).
REQ-025 Redirect in WAIT without imem_resp_valid: PC<=redirect_pc, go to DRAIN; DRAIN SHALL discard the next response, then go to REQ.
REQ-026 Redirect in WAIT coincident with imem_resp_valid: the response is discarded, PC<=redirect_pc, go to REQ.
REQ-027 Redirect in HOLD: inst_valid drops next cycle, PC<=redirect_pc, go to REQ; if inst_ready was also 1, the handshake counts (fetch_count+=1) and halt is ignored.
REQ-028 Redirect in DRAIN SHALL update PC and remain in DRAIN.
REQ-029 HALTED SHALL assert no outputs except fetch_count and ignore redirect/halt until reset.
REQ-030 At most one outstanding memory request SHALL exist at any time.

Reset
REQ-031 While reset_n=0: state=IDLE, PC=RESET_PC, inst=0, inst_pc=0, fetch_count=0, imem_req_valid=0, inst_valid=0, independent of clk.
REQ-032 Reset asserted mid-transaction SHALL abandon it; any imem response arriving after reset release while not in WAIT/DRAIN SHALL be ignored.

Structure
REQ-033 The state encoding and the constant PC_STEP=4 SHALL live in the shared CPU package/header alongside the opcode definitions.
REQ-034 The PC register with its next-PC mux (sequential +4, redirect, hold) SHALL be a sub-module named pc_register; the FSM, IR and counter stay in the top.

Verification
REQ-035 Reset release, memory always ready with 1-cycle response, inst_ready=1 -> inst_pc sequence 0,4,8,12; fetch_count=4 after the fourth handshake.
REQ-036 inst_ready held 0 for 5 cycles in HOLD -> inst and inst_pc unchanged, imem_req_valid=0, fetch_count unchanged.
REQ-037 Redirect to 32'h0000_0103 while in WAIT -> next response dropped, next request addr=32'h0000_0100, next inst_pc=32'h100.
REQ-038 RESET_PC=32'hFFFF_FFFC, two fetches -> inst_pc 32'hFFFF_FFFC then 32'h0000_0000.
REQ-039 halt=1 at the handshake of the third instruction -> HALTED, imem_req_valid stays 0, fetch_count=3.
REQ-040 reset_n pulsed low mid-WAIT -> outputs at reset values immediately; first request after release at RESET_PC.

Source files
------------

// File: rtl/instruction_fetch_unit_pkg.sv
// Shared CPU definitions: fetch FSM encoding, PC step and RV32I base opcodes.
// Used by the fetch unit and its PC register.
package instruction_fetch_unit_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_REQ    = 3'd1,
        S_WAIT   = 3'd2,
        S_DRAIN  = 3'd3,
        S_HOLD   = 3'd4,
        S_HALTED = 3'd5
    } fetch_state_e;

    localparam logic [31:0] PC_STEP = 32'd4;

    // Major opcodes (inst[6:0]) consumed by the decode stage.
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & ~32'd3;
    endfunction

endpackage

// File: rtl/instruction_fetch_unit_pc_register.sv
// Program counter with its next-PC mux: redirect (word aligned) over sequential
// advance over hold.
module pc_register
    import instruction_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        load_i,
    input  logic [31:0] load_pc_i,
    input  logic        advance_i,
    output logic [31:0] pc_o
);

    logic [31:0] pc_q;
    logic [31:0] pc_d;

    always_comb begin
        pc_d = pc_q;
        if (load_i) begin
            pc_d = word_align(load_pc_i);
        end else if (advance_i) begin
            pc_d = pc_q + PC_STEP;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Single-outstanding-request instruction fetch stage: issues a fetch at PC,
// latches the response into the instruction register and hands it to decode.
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        inst_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    output logic [31:0] fetch_count
);

    fetch_state_e state_q;
    logic         imem_req_valid_q;
    logic         inst_valid_q;
    logic [31:0]  inst_q;
    logic [31:0]  inst_pc_q;
    logic [31:0]  fetch_count_q;
    logic [31:0]  pc;
    logic         pc_load;
    logic         pc_advance;

    // Redirects are honoured in every live state; only an accepted response advances.
    assign pc_load    = redirect_valid && (state_q != S_HALTED);
    assign pc_advance = (state_q == S_WAIT) && imem_resp_valid && !redirect_valid;

    pc_register #(
        .RESET_PC (RESET_PC)
    ) u_pc_register (
        .clk       (clk),
        .reset_n   (reset_n),
        .load_i    (pc_load),
        .load_pc_i (redirect_pc),
        .advance_i (pc_advance),
        .pc_o      (pc)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q          <= S_IDLE;
            imem_req_valid_q <= 1'b0;
            inst_valid_q     <= 1'b0;
            inst_q           <= 32'd0;
            inst_pc_q        <= 32'd0;
            fetch_count_q    <= 32'd0;
        end else begin
            imem_req_valid_q <= 1'b0;
            inst_valid_q     <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    state_q          <= S_REQ;
                    imem_req_valid_q <= 1'b1;
                end
                S_REQ: begin
                    // An accepted request that is redirected must still be drained.
                    if (imem_req_ready && redirect_valid) begin
                        state_q <= S_DRAIN;
                    end else if (imem_req_ready) begin
                        state_q <= S_WAIT;
                    end else begin
                        state_q          <= S_REQ;
                        imem_req_valid_q <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (redirect_valid) begin
                        if (imem_resp_valid) begin
                            state_q          <= S_REQ;
                            imem_req_valid_q <= 1'b1;
                        end else begin
                            state_q <= S_DRAIN;
                        end
                    end else if (imem_resp_valid) begin
                        inst_q       <= imem_resp_data;
                        inst_pc_q    <= pc;
                        state_q      <= S_HOLD;
                        inst_valid_q <= 1'b1;
                    end else begin
                        state_q <= S_WAIT;
                    end
                end
                S_DRAIN: begin
                    if (imem_resp_valid) begin
                        state_q          <= S_REQ;
                        imem_req_valid_q <= 1'b1;
                    end else begin
                        state_q <= S_DRAIN;
                    end
                end
                S_HOLD: begin
                    if (inst_ready) begin
                        fetch_count_q <= fetch_count_q + 32'd1;
                    end
                    if (redirect_valid || (inst_ready && !halt)) begin
                        state_q          <= S_REQ;
                        imem_req_valid_q <= 1'b1;
                    end else if (inst_ready) begin
                        state_q <= S_HALTED;
                    end else begin
                        state_q      <= S_HOLD;
                        inst_valid_q <= 1'b1;
                    end
                end
                S_HALTED: begin
                    state_q <= S_HALTED;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign imem_req_valid = imem_req_valid_q;
    assign imem_req_addr  = pc;
    assign inst_valid     = inst_valid_q;
    assign inst           = inst_q;
    assign inst_pc        = inst_pc_q;
    assign fetch_count    = fetch_count_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for the fetch unit; a second instance with RESET_PC at the top
// of the address space shares the stimulus to check PC wrap.
module tb_instruction_fetch_unit;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        imem_req_ready = 1'b0;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data = 32'd0;
    logic        inst_ready = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        halt = 1'b0;

    logic        imem_req_valid, d2_imem_req_valid;
    logic [31:0] imem_req_addr, d2_imem_req_addr;
    logic        inst_valid, d2_inst_valid;
    logic [31:0] inst, d2_inst;
    logic [31:0] inst_pc, d2_inst_pc;
    logic [31:0] fetch_count, d2_fetch_count;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    instruction_fetch_unit dut (
        .clk (clk), .reset_n (reset_n),
        .imem_req_valid (imem_req_valid), .imem_req_addr (imem_req_addr),
        .imem_req_ready (imem_req_ready), .imem_resp_valid (imem_resp_valid),
        .imem_resp_data (imem_resp_data), .inst_valid (inst_valid),
        .inst (inst), .inst_pc (inst_pc), .inst_ready (inst_ready),
        .redirect_valid (redirect_valid), .redirect_pc (redirect_pc),
        .halt (halt), .fetch_count (fetch_count)
    );

    instruction_fetch_unit #(.RESET_PC (32'hFFFF_FFFC)) dut2 (
        .clk (clk), .reset_n (reset_n),
        .imem_req_valid (d2_imem_req_valid), .imem_req_addr (d2_imem_req_addr),
        .imem_req_ready (imem_req_ready), .imem_resp_valid (imem_resp_valid),
        .imem_resp_data (imem_resp_data), .inst_valid (d2_inst_valid),
        .inst (d2_inst), .inst_pc (d2_inst_pc), .inst_ready (inst_ready),
        .redirect_valid (redirect_valid), .redirect_pc (redirect_pc),
        .halt (halt), .fetch_count (d2_fetch_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_req();
        int n = 0;
        while (!imem_req_valid && n < 20) begin
            tick();
            n++;
        end
        chk("req_seen", {31'd0, imem_req_valid}, 32'd1);
    endtask

    task automatic mem_accept();
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
    endtask

    task automatic mem_respond(input logic [31:0] data);
        imem_resp_valid = 1'b1;
        imem_resp_data  = data;
        tick();
        imem_resp_valid = 1'b0;
    endtask

    task automatic consume();
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Asynchronous reset before any clock edge.
        #2 reset_n = 1'b0;
        #1;
        chk("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
        chk("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
        chk("rst_inst", inst, 32'd0);
        chk("rst_inst_pc", inst_pc, 32'd0);
        chk("rst_count", fetch_count, 32'd0);
        chk("rst_addr", imem_req_addr, 32'd0);
        chk("rst_addr_d2", d2_imem_req_addr, 32'hFFFF_FFFC);
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        chk("idle_to_req", {31'd0, imem_req_valid}, 32'd1);

        // Back-to-back fetches, memory ready with 1-cycle response.
        for (int i = 0; i < 4; i++) begin
            wait_req();
            chk("seq_addr", imem_req_addr, 32'(4 * i));
            mem_accept();
            chk("seq_wait_noreq", {31'd0, imem_req_valid}, 32'd0);
            mem_respond(32'hA000_0000 + 32'(i));
            chk("seq_valid", {31'd0, inst_valid}, 32'd1);
            chk("seq_inst", inst, 32'hA000_0000 + 32'(i));
            chk("seq_inst_pc", inst_pc, 32'(4 * i));
            chk("wrap_inst_pc_d2", d2_inst_pc, 32'hFFFF_FFFC + 32'(4 * i));
            consume();
            chk("seq_count", fetch_count, 32'(i + 1));
        end
        chk("seq_count_final", fetch_count, 32'd4);

        // Stall in HOLD for five cycles.
        wait_req();
        mem_accept();
        mem_respond(32'hCAFE_0005);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_inst", inst, 32'hCAFE_0005);
            chk("stall_inst_pc", inst_pc, 32'd16);
            chk("stall_noreq", {31'd0, imem_req_valid}, 32'd0);
            chk("stall_valid", {31'd0, inst_valid}, 32'd1);
            chk("stall_count", fetch_count, 32'd4);
        end
        consume();
        chk("stall_count_after", fetch_count, 32'd5);

        // Redirect while waiting: drain the stale response, refetch at aligned target.
        wait_req();
        chk("pre_redir_addr", imem_req_addr, 32'd20);
        mem_accept();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0103;
        tick();
        redirect_valid = 1'b0;
        chk("drain_noreq", {31'd0, imem_req_valid}, 32'd0);
        mem_respond(32'hDEAD_BEEF);
        chk("drain_no_inst", {31'd0, inst_valid}, 32'd0);
        chk("drain_req", {31'd0, imem_req_valid}, 32'd1);
        chk("drain_addr", imem_req_addr, 32'h0000_0100);
        mem_accept();
        mem_respond(32'h1111_0100);
        chk("redir_inst", inst, 32'h1111_0100);
        chk("redir_inst_pc", inst_pc, 32'h0000_0100);
        consume();
        chk("redir_count", fetch_count, 32'd6);

        // Redirect in HOLD with a concurrent handshake: counts, halt ignored.
        wait_req();
        chk("hold_pre_addr", imem_req_addr, 32'h0000_0104);
        mem_accept();
        mem_respond(32'h2222_0104);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0200;
        halt           = 1'b1;
        consume();
        redirect_valid = 1'b0;
        halt           = 1'b0;
        chk("hold_redir_count", fetch_count, 32'd7);
        chk("hold_redir_novalid", {31'd0, inst_valid}, 32'd0);
        chk("hold_redir_req", {31'd0, imem_req_valid}, 32'd1);
        chk("hold_redir_addr", imem_req_addr, 32'h0000_0200);

        // Redirect coincident with the response: response dropped.
        mem_accept();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0300;
        mem_respond(32'h0BAD_0BAD);
        redirect_valid = 1'b0;
        chk("coinc_novalid", {31'd0, inst_valid}, 32'd0);
        chk("coinc_req", {31'd0, imem_req_valid}, 32'd1);
        chk("coinc_addr", imem_req_addr, 32'h0000_0300);

        // Redirect while the request is being accepted: goes through DRAIN.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0400;
        mem_accept();
        redirect_valid = 1'b0;
        chk("reqacc_drain_noreq", {31'd0, imem_req_valid}, 32'd0);
        mem_respond(32'h0BAD_0400);
        chk("reqacc_novalid", {31'd0, inst_valid}, 32'd0);
        chk("reqacc_addr", imem_req_addr, 32'h0000_0400);

        // Reset pulsed mid-WAIT; stray response after release is ignored.
        mem_accept();
        reset_n = 1'b0;
        #1;
        chk("midrst_req_valid", {31'd0, imem_req_valid}, 32'd0);
        chk("midrst_inst_valid", {31'd0, inst_valid}, 32'd0);
        chk("midrst_inst", inst, 32'd0);
        chk("midrst_inst_pc", inst_pc, 32'd0);
        chk("midrst_count", fetch_count, 32'd0);
        tick();
        reset_n = 1'b1;
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'hEEEE_EEEE;
        tick();
        imem_resp_valid = 1'b0;
        chk("post_rst_novalid", {31'd0, inst_valid}, 32'd0);
        chk("post_rst_req", {31'd0, imem_req_valid}, 32'd1);
        chk("post_rst_addr", imem_req_addr, 32'd0);

        // Halt at the third handshake.
        for (int i = 0; i < 3; i++) begin
            wait_req();
            chk("halt_addr", imem_req_addr, 32'(4 * i));
            mem_accept();
            mem_respond(32'hB000_0000 + 32'(i));
            chk("halt_inst", inst, 32'hB000_0000 + 32'(i));
            halt = (i == 2);
            consume();
            halt = 1'b0;
        end
        imem_req_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0800;
        for (int i = 0; i < 5; i++) begin
            chk("halted_noreq", {31'd0, imem_req_valid}, 32'd0);
            chk("halted_novalid", {31'd0, inst_valid}, 32'd0);
            chk("halted_count", fetch_count, 32'd3);
            tick();
        end
        imem_req_ready = 1'b0;
        redirect_valid = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
